// File: rtl/square_pkg.sv
// Shared widths and the reference 4-bit square table used by the squarer.
package square_pkg;

  localparam int SQ_IN_W  = 4;
  localparam int SQ_OUT_W = 8;
  localparam logic [SQ_OUT_W-1:0] SQ_MAX = 8'd64;

  // Table lookup of x*x for a signed 4-bit code; unknown codes yield all-X.
  function automatic logic [SQ_OUT_W-1:0] sq4(input logic [SQ_IN_W-1:0] code);
    case (code)
      4'd0:    sq4 = 8'd0;
      4'd1:    sq4 = 8'd1;
      4'd2:    sq4 = 8'd4;
      4'd3:    sq4 = 8'd9;
      4'd4:    sq4 = 8'd16;
      4'd5:    sq4 = 8'd25;
      4'd6:    sq4 = 8'd36;
      4'd7:    sq4 = 8'd49;
      4'd8:    sq4 = SQ_MAX;
      4'd9:    sq4 = 8'd49;
      4'd10:   sq4 = 8'd36;
      4'd11:   sq4 = 8'd25;
      4'd12:   sq4 = 8'd16;
      4'd13:   sq4 = 8'd9;
      4'd14:   sq4 = 8'd4;
      4'd15:   sq4 = 8'd1;
      default: sq4 = 8'bx;
    endcase
  endfunction

endpackage

// File: rtl/square_lut_4_bit_rom.sv
// Combinational 16-entry square ROM indexed by the raw two's-complement code.
module square_lut_4_bit_rom
  import square_pkg::*;
(
  input  logic        [SQ_IN_W-1:0]  code,
  output logic signed [SQ_OUT_W-1:0] sq
);

  always_comb begin
    case (code)
      4'd0:    sq = 8'sd0;
      4'd1:    sq = 8'sd1;
      4'd2:    sq = 8'sd4;
      4'd3:    sq = 8'sd9;
      4'd4:    sq = 8'sd16;
      4'd5:    sq = 8'sd25;
      4'd6:    sq = 8'sd36;
      4'd7:    sq = 8'sd49;
      4'd8:    sq = $signed(SQ_MAX);
      4'd9:    sq = 8'sd49;
      4'd10:   sq = 8'sd36;
      4'd11:   sq = 8'sd25;
      4'd12:   sq = 8'sd16;
      4'd13:   sq = 8'sd9;
      4'd14:   sq = 8'sd4;
      4'd15:   sq = 8'sd1;
      // Unknown inputs must not masquerade as a valid square.
      default: sq = 8'bx;
    endcase
  end

endmodule

// File: rtl/square_lut_4_bit.sv
// 4-bit signed squarer: combinational ROM output plus a one-cycle registered copy.
module square_lut_4_bit
  import square_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SQ_IN_W-1:0]  in,
  input  logic                       in_valid,
  output logic signed [SQ_OUT_W-1:0] out,
  output logic signed [SQ_OUT_W-1:0] out_q,
  output logic                       out_valid
);

  logic signed [SQ_OUT_W-1:0] sq_p0;
  logic signed [SQ_OUT_W-1:0] sq_p1;
  logic                       vld_p1;

  // Stage p0: table lookup
  square_lut_4_bit_rom u_rom (
    .code (in),
    .sq   (sq_p0)
  );

  assign out = sq_p0;

  // Stage p1: registered result; reset clears the data too so out_q reads 0 after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) sq_p1 <= sq_p0;
    end
  end

  assign out_q     = sq_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_square_lut_4_bit.sv
// Bench for square_lut_4_bit: arithmetic reference model plus directed and random stimulus.
module tb_square_lut_4_bit;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [3:0] in_s = 4'sd0;
  logic              in_valid = 1'b0;
  logic signed [7:0] out, out_q;
  logic              out_valid;

  int errors = 0;
  int checks = 0;

  int  m_q = 0;
  bit  m_v = 1'b0;
  bit  m_known = 1'b0;
  int  sym_pos [1:7];

  square_lut_4_bit dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_s),
    .in_valid  (in_valid),
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: square by plain arithmetic, registered per the reset/valid rules.
  always @(posedge clk) begin
    if (rst) begin
      m_q = 0;
      m_v = 1'b0;
      m_known = 1'b1;
    end else if (in_valid) begin
      m_q = int'(in_s) * int'(in_s);
      m_v = 1'b1;
    end else begin
      m_v = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("comb_out", int'(out), int'(in_s) * int'(in_s));
    if (m_known) begin
      chk("out_q", int'(out_q), m_q);
      chk("out_valid", int'(out_valid), int'(m_v));
    end
  end

  // Inputs change 1 time unit after posedge; outputs seen on return reflect this edge.
  task automatic step(input bit r, input bit v, input int x);
    rst = r;
    in_valid = v;
    in_s = 4'(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Exhaustive combinational sweep
    for (int i = -8; i <= 7; i++) begin
      in_s = 4'(i);
      #1;
      chk("sweep", int'(out), i * i);
      chk("bit7", int'(out[7]), 0);
      if (i > 0) sym_pos[i] = int'(out);
    end
    for (int k = 1; k <= 7; k++) begin
      in_s = 4'(-k);
      #1;
      chk("symmetry", int'(out), sym_pos[k]);
    end
    in_s = -4'sd8; #1; chk("lit_m8", int'(out), 64);
    in_s = -4'sd3; #1; chk("lit_m3", int'(out), 9);
    in_s = 4'sd0;  #1; chk("lit_0", int'(out), 0);
    in_s = 4'sd7;  #1; chk("lit_7", int'(out), 49);

    @(posedge clk); #1;
    // Reset held with valid input present
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b1, 5);
      chk("rst_out_q", int'(out_q), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out", int'(out), 25);
    end

    // Back-to-back pipeline
    step(1'b0, 1'b1, -8);
    chk("pipe0_q", int'(out_q), 64); chk("pipe0_v", int'(out_valid), 1);
    step(1'b0, 1'b1, 3);
    chk("pipe1_q", int'(out_q), 9);  chk("pipe1_v", int'(out_valid), 1);
    step(1'b0, 1'b1, -1);
    chk("pipe2_q", int'(out_q), 1);  chk("pipe2_v", int'(out_valid), 1);

    // Idle: input changes without valid
    in_valid = 1'b0;
    in_s = 4'sd6;
    #1;
    chk("idle_comb", int'(out), 36);
    step(1'b0, 1'b0, 6);
    chk("idle_q", int'(out_q), 1);
    chk("idle_v", int'(out_valid), 0);

    // Mid-stream reset drops the accepted value
    step(1'b0, 1'b1, 2);
    chk("pre_rst_q", int'(out_q), 4);
    step(1'b1, 1'b1, -7);
    chk("mid_rst_q", int'(out_q), 0);
    chk("mid_rst_v", int'(out_valid), 0);
    step(1'b0, 1'b0, 0);
    chk("post_rst_q", int'(out_q), 0);
    chk("post_rst_v", int'(out_valid), 0);

    // Random traffic checked every cycle by the model
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 15)) - 8);
    end

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
